truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//   Upstream stimulus/capture stage for 4-input combinational blocks of the one_b family.
//   On start, drives every input vector 0..2^N_IN-1 in order, holding each for HOLD_CYCLES clocks.
//   Samples the DUT output f once per vector and packs the samples into a truth-table word.
//   Replaces hand-written per-vector stimulus and gives a synthesizable, self-checkable sweep.
// PARAMETERS
//   N_IN         4    number of DUT inputs; vec width; result width is 2**N_IN
//   HOLD_CYCLES  20   clocks each vector is held before f is sampled; legal range >= 1
// PORTS
//   clk         in   1            rising-edge clock
//   rst         in   1            synchronous, active-high reset
//   start       in   1            pulse/level; accepted only in IDLE
//   vec         out  N_IN         DUT inputs; vec[N_IN-1] drives A ... vec[0] drives D (for N_IN=4)
//   f           in   1            DUT output, combinational from vec
//   busy        out  1            high while sweeping (DRIVE state)
//   done        out  1            single-cycle pulse when a sweep completes
//   result      out  2**N_IN      bit i = f sampled while vec==i
//   ones_count  out  N_IN+1       number of vectors with f==1
// BEHAVIOUR
//   Reset (rst high at a clk edge): state=IDLE; vec, result, ones_count, hold counter = 0;
//     busy=0, done=0. Reset takes priority over every other event, including mid-sweep.
//   States: IDLE -> DRIVE -> DONE -> IDLE.
//   IDLE:  vec=0. result and ones_count keep the last sweep's values.
//     On an edge with start=1: result=0, ones_count=0, vec=0, cnt=0; go to DRIVE.
//   DRIVE: busy=1.
//     Each edge with cnt<HOLD_CYCLES-1: cnt++. vec is unchanged.
//     Edge with cnt==HOLD_CYCLES-1: result[vec]<=f; ones_count += f; cnt<=0.
//       If vec==2**N_IN-1, go to DONE and leave vec unchanged.
//       Otherwise vec<=vec+1.
//   DONE:  busy=0, done=1 for exactly one cycle. vec returns to 0 on exit. Next edge goes to IDLE.
//   Timing: start accepted at edge E0.
//     Vector i is driven from edge E0+i*HOLD_CYCLES.
//     Vector i is sampled at edge E0+(i+1)*HOLD_CYCLES.
//     done is high during the cycle after edge E0+(2**N_IN)*HOLD_CYCLES.
//     Sweep length is 2**N_IN*HOLD_CYCLES+1 cycles from start to done fall.
//   start while in DRIVE or DONE is ignored; no queuing.
//   HOLD_CYCLES=1: one vector per clock. f is sampled at the same edge that advances vec.
//   ones_count never wraps: its width holds 2**N_IN.
//   result and ones_count are registered outputs. They update only at sample edges, on start, and on reset.
//   Outputs are glitch-free registers. No combinational path from f to any output.
// TESTING
//   1. DUT model f=^vec, N_IN=4, HOLD_CYCLES=20, pulse start
//        -> done at cycle 321 after start; result=16'h6996; ones_count=8.
//   2. DUT model f=A&B | C&~D
//        -> result=16'hF444 (bits 2,6,10,12-15 set... check against model);
//        -> ones_count = popcount of the model table; bench compares against a software model.
//   3. HOLD_CYCLES=1, f=1
//        -> vec steps 0..15 on consecutive cycles; result=16'hFFFF;
//        -> ones_count=16; done at cycle 17.
//   4. start held high through an entire sweep
//        -> exactly one sweep per IDLE entry; busy drops for the DONE+IDLE cycles; no mid-sweep restart.
//   5. rst asserted while vec==5 in DRIVE
//        -> next edge: vec=0, result=0, ones_count=0, busy=0, done=0.
//        -> A following start sweeps from vec=0.
//   6. f=0 constant, then a second sweep with f=1
//        -> first result=0/count=0; result is held in IDLE;
//        -> it clears on the second start and ends at 16'hFFFF/16.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between the truth-table sweeper and the block under test / controller.
// master: drives start and the DUT response f; slave: the sweeper itself.
interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);
  logic                 start;
  logic [N_IN-1:0]      vec;
  logic                 f;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   result;
  logic [N_IN:0]        ones_count;

  modport master (
    output start, f,
    input  vec, busy, done, result, ones_count
  );

  modport slave (
    input  start, f,
    output vec, busy, done, result, ones_count
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives every input vector of an N_IN-input combinational block in order, holds each
// for HOLD_CYCLES clocks, and packs the sampled output f into a truth-table word.
module truth_table_sweeper #(
  parameter int N_IN        = 4,
  parameter int HOLD_CYCLES = 20
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_sweeper_if.slave bus
);
  localparam int NV = 2**N_IN;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  state_t          state_q, state_n;
  logic [N_IN-1:0] vec_q, vec_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [NV-1:0]   result_q, result_n;
  logic [N_IN:0]   ones_q, ones_n;
  logic            busy_q, done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ones_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      vec_q    <= vec_n;
      cnt_q    <= cnt_n;
      result_q <= result_n;
      ones_q   <= ones_n;
      // busy/done registered from the next state so they track state_q without decode glitches
      busy_q   <= (state_n == DRIVE);
      done_q   <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n  = state_q;
    vec_n    = vec_q;
    cnt_n    = cnt_q;
    result_n = result_q;
    ones_n   = ones_q;
    unique case (state_q)
      IDLE: begin
        vec_n = '0;
        cnt_n = '0;
        if (bus.start) begin
          result_n = '0;
          ones_n   = '0;
          state_n  = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q != CNT_LAST) begin
          cnt_n = cnt_q + 1'b1;
        end else begin
          cnt_n            = '0;
          result_n[vec_q]  = bus.f;
          ones_n           = ones_q + {{N_IN{1'b0}}, bus.f};
          if (vec_q == '1) state_n = DONE;
          else             vec_n   = vec_q + 1'b1;
        end
      end
      DONE: begin
        // last vector stays on the bus through the done cycle, then returns to 0
        vec_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.vec        = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.ones_count = ones_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: two instances (hold 20 and hold 1)
// checked against a truth-table reference model and the sweep timing rules.
module tb_truth_table_sweeper;
  localparam int N_IN = 4;
  localparam int NV   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(N_IN)) bus_a ();
  truth_table_sweeper_if #(.N_IN(N_IN)) bus_b ();

  logic [15:0] tbl_a, tbl_b;
  assign bus_a.f = tbl_a[bus_a.vec];
  assign bus_b.f = tbl_b[bus_b.vec];

  truth_table_sweeper #(.N_IN(N_IN), .HOLD_CYCLES(20)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  truth_table_sweeper #(.N_IN(N_IN), .HOLD_CYCLES(1)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  int sel        = 0;

  logic [3:0]  vec_s;
  logic        busy_s, done_s;
  logic [15:0] res_s;
  logic [4:0]  ones_s;

  always_comb begin
    if (sel == 0) begin
      vec_s = bus_a.vec; busy_s = bus_a.busy; done_s = bus_a.done;
      res_s = bus_a.result; ones_s = bus_a.ones_count;
    end else begin
      vec_s = bus_b.vec; busy_s = bus_b.busy; done_s = bus_b.done;
      res_s = bus_b.result; ones_s = bus_b.ones_count;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) bus_a.start = v;
    else          bus_b.start = v;
  endtask

  // Reference truth tables: A=v[3] .. D=v[0]
  function automatic logic [15:0] model_table(input int mode, input logic [15:0] rnd);
    logic [15:0] t;
    logic [3:0]  v;
    t = '0;
    for (int i = 0; i < NV; i++) begin
      v = 4'(i);
      case (mode)
        0:       t[i] = ^v;
        1:       t[i] = (v[3] & v[2]) | (v[1] & ~v[0]);
        2:       t[i] = rnd[i];
        3:       t[i] = 1'b0;
        default: t[i] = 1'b1;
      endcase
    end
    return t;
  endfunction

  task automatic wait_done(input string tag, input int bound);
    int k;
    k = 0;
    while (!done_s && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, " done_seen"}, {31'd0, done_s}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic sweep(input int mode, input logic [15:0] rnd, input bit keep_start, input string tag);
    logic [15:0] t;
    int ones, hold, k, exp_vec;
    bit seen;
    hold = (sel == 0) ? 20 : 1;
    t = model_table(mode, rnd);
    ones = 0;
    for (int i = 0; i < NV; i++) ones += int'(t[i]);
    @(negedge clk);
    if (sel == 0) tbl_a = t; else tbl_b = t;
    set_start(1'b1);
    @(posedge clk); #1;
    if (!keep_start) set_start(1'b0);
    check({tag, " clr_result"}, 32'(res_s), 32'd0);
    check({tag, " clr_ones"}, 32'(ones_s), 32'd0);
    check({tag, " busy_start"}, 32'(busy_s), 32'd1);
    check({tag, " vec0"}, 32'(vec_s), 32'd0);
    k = 0;
    seen = 0;
    while (!seen && k < NV * hold + 8) begin
      @(posedge clk); #1;
      k++;
      if (done_s) seen = 1;
      else begin
        exp_vec = (k / hold > 15) ? 15 : k / hold;
        check({tag, " vec"}, 32'(vec_s), 32'(exp_vec));
        check({tag, " busy"}, 32'(busy_s), 32'd1);
      end
    end
    check({tag, " done_latency"}, 32'(k), 32'(NV * hold));
    check({tag, " busy_done"}, 32'(busy_s), 32'd0);
    check({tag, " vec_done"}, 32'(vec_s), 32'd15);
    check({tag, " result"}, 32'(res_s), 32'(t));
    check({tag, " ones"}, 32'(ones_s), 32'(ones));
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 32'(done_s), 32'd0);
    check({tag, " busy_idle"}, 32'(busy_s), 32'd0);
    check({tag, " vec_idle"}, 32'(vec_s), 32'd0);
    if (keep_start) begin
      @(posedge clk); #1;
      check({tag, " restart_busy"}, 32'(busy_s), 32'd1);
      check({tag, " restart_vec"}, 32'(vec_s), 32'd0);
      set_start(1'b0);
      wait_done({tag, " restart"}, NV * hold + 8);
      check({tag, " restart_result"}, 32'(res_s), 32'(t));
      check({tag, " restart_busy_idle"}, 32'(busy_s), 32'd0);
    end
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    tbl_a = '0;
    tbl_b = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check("reset vec", 32'(vec_s), 32'd0);
      check("reset result", 32'(res_s), 32'd0);
      check("reset ones", 32'(ones_s), 32'd0);
      check("reset busy", 32'(busy_s), 32'd0);
      check("reset done", 32'(done_s), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // parity, hold 20
    sel = 0;
    sweep(0, 16'h0, 1'b0, "parity");
    check("parity const", 32'(res_s), 32'h6996);
    check("parity count", 32'(ones_s), 32'd8);

    // A&B | C&~D
    sweep(1, 16'h0, 1'b0, "ab_cnd");
    check("ab_cnd const", 32'(res_s), 32'hF444);

    // hold 1, f=1
    sel = 1;
    sweep(4, 16'h0, 1'b0, "h1_ones");
    check("h1_ones count", 32'(ones_s), 32'd16);

    // start held through the sweep
    sweep(1, 16'h0, 1'b1, "held_start");

    // f=0 then f=1, with result held in IDLE
    sweep(3, 16'h0, 1'b0, "const0");
    repeat (4) @(posedge clk);
    #1;
    check("const0 held", 32'(res_s), 32'd0);
    sweep(4, 16'h0, 1'b0, "const1");
    repeat (4) @(posedge clk);
    #1;
    check("const1 held", 32'(res_s), 32'hFFFF);
    check("const1 held ones", 32'(ones_s), 32'd16);

    // random tables on both instances
    for (int r = 0; r < 4; r++) begin
      sel = 1;
      sweep(2, 16'($urandom), 1'b0, "rand_h1");
    end
    sel = 0;
    sweep(2, 16'($urandom), 1'b0, "rand_h20");

    // reset while vec==5 mid-sweep
    @(negedge clk);
    tbl_a = 16'hFFFF;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    k = 0;
    while (vec_s != 4'd5 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("midrst vec5", 32'(vec_s), 32'd5);
    check("midrst partial", 32'(res_s), 32'h001F);
    check("midrst partial ones", 32'(ones_s), 32'd5);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst vec", 32'(vec_s), 32'd0);
    check("midrst result", 32'(res_s), 32'd0);
    check("midrst ones", 32'(ones_s), 32'd0);
    check("midrst busy", 32'(busy_s), 32'd0);
    check("midrst done", 32'(done_s), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sweep(2, 16'($urandom), 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
